// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter: tag layout, index sizing, latency bound.
// Tag index is sized for the largest supported requester count so one struct serves every build.
package mem_arb_pkg;

  localparam int MAX_LATENCY = 2;
  localparam int MAX_REQ     = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

  localparam int TAG_IDXW = clog2(MAX_REQ);

  typedef struct packed {
    logic                vld;
    logic [TAG_IDXW-1:0] idx;
  } tag_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Round-robin picker: combinational grant from the current pointer, pointer registered after each grant.
// Zero latency; en=0 suppresses the grant and freezes the pointer.
module mem_arb_rr
  import mem_arb_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         grant_vld
);

  logic [W-1:0] ptr;
  logic [W-1:0] sel;
  logic         found;
  int           j;

  // Search starts at the pointer and wraps, so the last winner has lowest priority next time.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j[W-1:0]]) begin
        found = 1'b1;
        sel   = j[W-1:0];
      end
    end
    grant_vld = en & found;
    grant_idx = sel;
    grant     = '0;
    if (grant_vld) grant[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
    end else if (grant_vld) begin
      ptr <= (sel == W'(N - 1)) ? '0 : sel + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port among NUM_REQ requesters, one access per cycle, returning read data to its issuer.
// Grant is same-cycle; read data returns MEM_LATENCY cycles after the grant edge; hold stalls grants only.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NUM_REQ       = 4,
  parameter  int MEM_DATAWIDTH = 128,
  parameter  int MEM_ADDRWIDTH = 14,
  parameter  int MEM_LATENCY   = 1,
  localparam int BEW           = (MEM_DATAWIDTH + 7) / 8,
  localparam int IDXW          = clog2(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               hold,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*BEW-1:0]             req_we,
  input  logic [NUM_REQ*MEM_ADDRWIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*MEM_DATAWIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                 resp_valid,
  output logic [MEM_DATAWIDTH-1:0]           resp_rdata,
  output logic                               busy,
  output logic                               mem_en,
  output logic [BEW-1:0]                     mem_we,
  output logic [MEM_ADDRWIDTH-1:0]           mem_addr,
  output logic [MEM_DATAWIDTH-1:0]           mem_din,
  input  logic [MEM_DATAWIDTH-1:0]           mem_dout
);

  logic [NUM_REQ-1:0] grant;
  logic [IDXW-1:0]    grant_idx;
  logic               grant_vld;
  tag_t               new_tag;
  tag_t               pipe [MEM_LATENCY];
  tag_t               tail;

  mem_arb_rr #(
    .N (NUM_REQ)
  ) u_rr (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .en        (~hold & reset),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign req_ready = grant;
  assign mem_en    = grant_vld;

  // One-hot AND-OR select; an all-zero grant drives zeros onto the memory bus.
  always_comb begin
    mem_we   = '0;
    mem_addr = '0;
    mem_din  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        mem_we   = mem_we   | req_we[i*BEW +: BEW];
        mem_addr = mem_addr | req_addr[i*MEM_ADDRWIDTH +: MEM_ADDRWIDTH];
        mem_din  = mem_din  | req_wdata[i*MEM_DATAWIDTH +: MEM_DATAWIDTH];
      end
    end
  end

  always_comb begin
    new_tag     = '0;
    new_tag.vld = grant_vld & (mem_we == '0);
    new_tag.idx = TAG_IDXW'(grant_idx);
  end

  // Tag pipeline mirrors the memory read latency; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < MEM_LATENCY; s++) begin
        pipe[s] <= '0;
      end
    end else begin
      pipe[0] <= new_tag;
      for (int s = 1; s < MEM_LATENCY; s++) begin
        pipe[s] <= pipe[s-1];
      end
    end
  end

  assign tail = pipe[MEM_LATENCY-1];

  always_comb begin
    resp_valid = '0;
    resp_rdata = '0;
    if (tail.vld) begin
      resp_rdata = mem_dout;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (tail.idx == TAG_IDXW'(i)) resp_valid[i] = 1'b1;
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < MEM_LATENCY; s++) begin
      busy = busy | pipe[s].vld;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one port of the dual-port memory wrapper between NUM_REQ requesters using round-robin arbitration.
- Issues at most one access per cycle. Tracks outstanding reads through a latency pipeline and routes read data back to the requester that issued the read.
- Sits between tile-local masters (DMA, core load/store, debug) and mem_dp_wrap port A or port B; the other memory port is unaffected.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MEM_DATAWIDTH, 128, data width; must match the memory.
- MEM_ADDRWIDTH, 14, word address width; must match the memory.
- MEM_LATENCY, 1, memory read latency in cycles (1 or 2).
- BEW, (MEM_DATAWIDTH+7)/8, byte-enable width (derived, not overridden).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- hold  in  1  when 1, no new grants are issued; in-flight reads still complete.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_we  in  NUM_REQ*BEW  byte enables, flattened with requester i at [i*BEW +: BEW]; all-zero means read.
- req_addr  in  NUM_REQ*MEM_ADDRWIDTH  flattened addresses.
- req_wdata  in  NUM_REQ*MEM_DATAWIDTH  flattened write data.
- resp_valid  out  NUM_REQ  read data valid, one-hot or zero; no backpressure.
- resp_rdata  out  MEM_DATAWIDTH  read data, shared by all requesters.
- busy  out  1  at least one read in flight.
- mem_en  out  1  to memory en.
- mem_we  out  BEW  to memory we.
- mem_addr  out  MEM_ADDRWIDTH  to memory addr.
- mem_din  out  MEM_DATAWIDTH  to memory din.
- mem_dout  in  MEM_DATAWIDTH  from memory dout.

Behaviour:
- Reset (reset=0 at a clk edge):
  - Round-robin pointer goes to 0 and the tag pipeline is cleared.
  - resp_valid=0 and busy=0 from the next cycle.
  - Reads in flight when reset is applied are dropped and never produce resp_valid.
  - During reset, req_ready and mem_en are forced to 0.
- Arbitration is combinational in the same cycle:
  - The winner is the first i with req_valid[i]=1, searching pointer, pointer+1, …, wrapping modulo NUM_REQ.
  - A grant occurs when a winner exists, hold=0 and reset=1. Then req_ready[winner]=1, mem_en=1, and mem_we/mem_addr/mem_din come from the winner's slices.
  - With no grant: mem_en=0, mem_we=0, and mem_addr/mem_din are 0.
- Handshake:
  - A transfer completes when req_valid[i] and req_ready[i] are both 1 at a clk edge.
  - req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
  - A requester must hold valid, we, addr and wdata stable until accepted.
- Pointer update: after a grant to i, the pointer becomes (i+1) mod NUM_REQ. With no grant, the pointer is unchanged.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles while hold=0.
- Read tracking:
  - A granted read (mem_we==0) pushes the tag {1, winner index} into a MEM_LATENCY-deep shift register.
  - Writes push {0, x}.
  - When a valid tag reaches the end of the pipeline, MEM_LATENCY cycles after the grant edge, resp_valid[index]=1 and resp_rdata=mem_dout in that cycle.
  - Otherwise resp_valid=0 and resp_rdata=0.
- Throughput: back-to-back grants every cycle, including read-after-write to the same address. The memory's read-during-write behaviour applies unchanged.
- busy is the OR of the valid bits of all pipeline stages.
- hold asserted mid-stream: the grant stops in the same cycle, the pointer freezes, and already-issued reads still return.

Decomposition:
- Package mem_arb_pkg:
  - function clog2 for the index width IDXW=clog2(NUM_REQ).
  - tag struct {logic vld; logic [IDXW-1:0] idx}.
  - constant MAX_LATENCY=2.
- Sub-module mem_arb_rr: combinational round-robin grant plus registered pointer.
  - Parameter N.
  - Inputs: clk, reset, req, en.
  - Outputs: grant (one-hot), grant_idx, grant_vld.
- Top level contains slice muxing, tag pipeline and response routing.

Test Plan:
- Reset then idle: after reset=0 for 2 cycles and release, with req_valid=0 → mem_en=0, resp_valid=0, busy=0 for 10 cycles.
- Single read: after a write of 0xA5… to addr 0x10, requester 2 reads addr 0x10 (MEM_LATENCY=1) → req_ready[2]=1 at grant, resp_valid=4'b0100 one cycle later, resp_rdata=0xA5…
- All four requesters valid continuously with reads to addr=i → grant order 0,1,2,3,0,… one per cycle; resp_valid one-hot in the same order, delayed by MEM_LATENCY.
- Requesters 1 and 3 valid with the pointer at 2 → 3 is granted first, then 1.
- hold=1 for 3 cycles during streaming reads → no mem_en; the 1 (or 2) in-flight reads still return; the pointer is unchanged when hold drops.
- reset=0 asserted the cycle after a read grant (MEM_LATENCY=2) → no resp_valid for that read, busy=0 after reset, and the next grant goes to requester 0 if valid.
